stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/clear sequencer for the 4-digit BCD stopwatch counter. Debounces the start
//  and clear buttons and decodes mode and load into preset, count-enable and direction
//  controls. Sits between the clock divider (tick) and the BCD counter/display datapath.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  clk cycles a synchronized button level must stay stable
//  CNT_W            18      debounce counter width; must hold DEBOUNCE_CYCLES
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous active-low reset
//  tick       in   1   one-clk strobe at the count rate (100 Hz)
//  start_btn  in   1   raw start/stop button, asynchronous
//  clear_btn  in   1   raw clear button, asynchronous
//  mode       in   2   00 up from 0; 01 up from preset; 10 down from 9999; 11 down from preset
//  load       in   8   [7:4] preset digit3, [3:0] preset digit2 (BCD)
//  at_max     in   1   counter reads 99.99
//  at_zero    in   1   counter reads 00.00
//  cnt_en     out  1   one-clk advance strobe to the counter
//  cnt_dir    out  1   0 = up, 1 = down
//  cnt_ld     out  1   preset strobe; counter loads ld_val
//  ld_val     out  16  BCD preset {d3,d2,d1,d0}
//  running    out  1   high in RUN
//  done       out  1   high in DONE
// BEHAVIOUR
//  - Reset: state IDLE; every output is 0, including ld_val. All outputs are registered.
//  - Button path, per button: 2-flop synchronizer, then debounce. Accept the level after
//    DEBOUNCE_CYCLES stable cycles. Emit a one-clk pulse on an accepted 0->1.
//    Pulse appears DEBOUNCE_CYCLES+3 clks after a clean edge.
//  - Preset decode: 00 -> 0000; 10 -> 9999; 01/11 -> {clamp(load[7:4]),clamp(load[3:0]),0,0}.
//    clamp(x) = (x>9) ? 9 : x.
//  - FSM states: IDLE, RUN, PAUSE, DONE.
//    IDLE : cnt_ld=1 and ld_val=preset(mode,load) every clk, so a live mode/load change is
//           tracked. start pulse -> RUN; latch cnt_dir=mode[1] on that transition.
//    RUN  : on tick, cnt_en=1 on the next clk unless terminal, where terminal =
//           cnt_dir ? at_zero : at_max. tick while terminal -> DONE with no cnt_en.
//           start -> PAUSE. clear -> IDLE.
//    PAUSE: cnt_en held 0. start -> RUN. clear -> IDLE.
//    DONE : counter frozen at its limit. start is ignored. clear -> IDLE.
//  - Mode changes outside IDLE have no effect; cnt_dir holds its latched value.
//    A new mode takes effect on the next IDLE.
//  - Simultaneous start and clear pulses: clear wins.
//  - tick in the same clk as a start pulse: the state transition happens first, and that
//    tick is consumed under the new state.
//  - Preset already at terminal (e.g. mode 11 with load 00): first tick in RUN -> DONE,
//    with zero cnt_en pulses.
//  - reset_n low mid-count: immediate IDLE, outputs 0. The first clk after release
//    asserts cnt_ld.
// CONFIGURATION
//  STOPWATCH_LAP_EN: adds input lap_btn (raw, debounced like start) and output
//   disp_hold (1). In RUN, a lap pulse toggles disp_hold; the display shows a frozen
//   copy while counting continues. disp_hold clears on IDLE or DONE entry.
//   Without the macro: no lap_btn or disp_hold port, and no lap logic.
// STRUCTURE
//  - Package stopwatch_pkg:
//    - state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//    - mode encodings
//    - BCD_MAX=4'd9
//    - PRESET_MAX=16'h9999
//  - Sub-module btn_debounce (synchronizer, debounce counter, rise pulse), one instance
//    per button.
// TESTING (bench overrides DEBOUNCE_CYCLES=4)
//  - Reset then mode=00, start press: 1 cnt_ld-only phase in IDLE, RUN entered; 5 ticks
//    -> 5 cnt_en pulses, cnt_dir=0.
//  - mode=11, load=8'h3A: ld_val=16'h3900. Start, at_zero forced, tick -> DONE,
//    no cnt_en.
//  - RUN, start press -> PAUSE; 3 ticks -> 0 cnt_en. Start -> RUN. Clear -> IDLE,
//    cnt_ld=1.
//  - Start and clear pulses in the same clk from RUN -> IDLE.
//  - Glitch shorter than 4 clks on start_btn -> no pulse, state unchanged.
//  - reset_n low for 1 clk during RUN -> all outputs 0, IDLE, mode change then tracked
//    in ld_val.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state/mode encodings and BCD preset helpers
// for the stopwatch run/pause/clear sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_UP_ZERO   = 2'b00,
    MODE_UP_PRESET = 2'b01,
    MODE_DN_MAX    = 2'b10,
    MODE_DN_PRESET = 2'b11
  } mode_t;

  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam logic [15:0] PRESET_MAX = 16'h9999;

  function automatic logic [3:0] bcd_clamp(
    input logic [3:0] x
  );
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

  function automatic logic [15:0] preset_val(
    input logic [1:0] mode,
    input logic [7:0] load
  );
    case (mode_t'(mode))
      MODE_UP_ZERO: return 16'h0000;
      MODE_DN_MAX:  return PRESET_MAX;
      default:
        return {bcd_clamp(load[7:4]),
                bcd_clamp(load[3:0]),
                8'h00};
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: control bus to the BCD counter datapath.
// master drives cnt_en/cnt_dir/cnt_ld/ld_val; slave returns at_max/at_zero.
interface stopwatch_ctrl_if;
  logic        cnt_en;
  logic        cnt_dir;
  logic        cnt_ld;
  logic [15:0] ld_val;
  logic        at_max;
  logic        at_zero;

  modport master (
    output cnt_en, cnt_dir, cnt_ld, ld_val,
    input  at_max, at_zero
  );

  modport slave (
    input  cnt_en, cnt_dir, cnt_ld, ld_val,
    output at_max, at_zero
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop sync, stable-level debounce, rise pulse.
// Ports: clk, reset_n, btn (raw async), pulse (one clk on accepted 0->1).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = 18
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             lvl;
  logic             lvl_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      pulse <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl_d <= lvl;
      pulse <= lvl & ~lvl_d;
      // any return to the accepted level restarts the window
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        lvl <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencer; clk, reset_n, tick, buttons,
// mode/load in; running/done out; cnt_if counter bus. Option: STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start_btn,
  input  logic       clear_btn,
  input  logic [1:0] mode,
  input  logic [7:0] load,
  output logic       running,
  output logic       done,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap_btn,
  output logic       disp_hold,
`endif
  stopwatch_ctrl_if.master cnt_if
);

  logic        start_p;
  logic        clr_p;
  state_t      state;
  state_t      st_b;
  state_t      nxt;
  logic        dir_q;
  logic        dir_b;
  logic        en_n;
  logic        en_q;
  logic        ld_q;
  logic [15:0] ldv_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_start (
    .clk(clk), .reset_n(reset_n),
    .btn(start_btn), .pulse(start_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_clear (
    .clk(clk), .reset_n(reset_n),
    .btn(clear_btn), .pulse(clr_p)
  );

  // button events resolve first; a tick in the
  // same clk is then judged under the new state
  always_comb begin
    st_b  = state;
    dir_b = dir_q;
    nxt   = state;
    en_n  = 1'b0;
    if (clr_p) begin
      st_b = ST_IDLE;
    end else if (start_p) begin
      unique case (state)
        ST_IDLE: begin
          st_b  = ST_RUN;
          dir_b = mode[1];
        end
        ST_RUN:   st_b = ST_PAUSE;
        ST_PAUSE: st_b = ST_RUN;
        ST_DONE:  st_b = ST_DONE;
      endcase
    end
    nxt = st_b;
    if (st_b == ST_RUN && tick) begin
      if (dir_b ? cnt_if.at_zero : cnt_if.at_max)
        nxt = ST_DONE;
      else
        en_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      dir_q   <= 1'b0;
      en_q    <= 1'b0;
      ld_q    <= 1'b0;
      ldv_q   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      dir_q   <= dir_b;
      en_q    <= en_n;
      ld_q    <= (nxt == ST_IDLE);
      running <= (nxt == ST_RUN);
      done    <= (nxt == ST_DONE);
      if (nxt == ST_IDLE)
        ldv_q <= preset_val(mode, load);
    end
  end

  assign cnt_if.cnt_en  = en_q;
  assign cnt_if.cnt_dir = dir_q;
  assign cnt_if.cnt_ld  = ld_q;
  assign cnt_if.ld_val  = ldv_q;

`ifdef STOPWATCH_LAP_EN
  logic lap_p;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_lap (
    .clk(clk), .reset_n(reset_n),
    .btn(lap_btn), .pulse(lap_p)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      disp_hold <= 1'b0;
    else if (nxt == ST_IDLE || nxt == ST_DONE)
      disp_hold <= 1'b0;
    else if (state == ST_RUN && lap_p)
      disp_hold <= ~disp_hold;
  end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed + random stimulus against an
// event-level reference model of the stopwatch sequencer.
module tb_stopwatch_ctrl;

  localparam int DC     = 4;
  localparam int SETTLE = DC + 6;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] load = 8'h00;
  logic       running;
  logic       done;
`ifdef STOPWATCH_LAP_EN
  logic       lap_btn = 1'b0;
  logic       disp_hold;
`endif

  stopwatch_ctrl_if cnt_if();

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tick(tick),
    .start_btn(start_btn),
    .clear_btn(clear_btn),
    .mode(mode),
    .load(load),
    .running(running),
    .done(done),
`ifdef STOPWATCH_LAP_EN
    .lap_btn(lap_btn),
    .disp_hold(disp_hold),
`endif
    .cnt_if(cnt_if.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int en_seen = 0;
  int exp_en = 0;
  int m_state = S_IDLE;
  bit m_dir = 1'b0;
  logic [15:0] m_ld = 16'h0000;

  always @(posedge clk)
    if (cnt_if.cnt_en === 1'b1) en_seen++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_preset(
    input int md, input int ld);
    int hi;
    int lo;
    hi = ld / 16;
    lo = ld % 16;
    if (md == 0) return 16'h0000;
    if (md == 2) return 16'h9999;
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return 16'(hi * 4096 + lo * 256);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".running"}, running, m_state == S_RUN);
    check({tag, ".done"}, done, m_state == S_DONE);
    check({tag, ".cnt_ld"}, cnt_if.cnt_ld,
          m_state == S_IDLE);
    check({tag, ".ld_val"}, cnt_if.ld_val, m_ld);
    check({tag, ".cnt_dir"}, cnt_if.cnt_dir, m_dir);
    check({tag, ".en_cnt"}, en_seen, exp_en);
  endtask

  task automatic press(input bit s, input bit c);
    @(negedge clk);
    start_btn = s;
    clear_btn = c;
    wait_clk(SETTLE);
    start_btn = 1'b0;
    clear_btn = 1'b0;
    wait_clk(SETTLE);
    if (c) begin
      m_state = S_IDLE;
    end else if (s) begin
      if (m_state == S_IDLE) begin
        m_state = S_RUN;
        m_dir = mode[1];
      end else if (m_state == S_RUN) begin
        m_state = S_PAUSE;
      end else if (m_state == S_PAUSE) begin
        m_state = S_RUN;
      end
    end
    if (m_state == S_IDLE) m_ld = ref_preset(mode, load);
  endtask

  task automatic do_tick(input bit az, input bit am);
    @(negedge clk);
    tick = 1'b1;
    cnt_if.at_zero = az;
    cnt_if.at_max = am;
    @(negedge clk);
    tick = 1'b0;
    cnt_if.at_zero = 1'b0;
    cnt_if.at_max = 1'b0;
    wait_clk(2);
    if (m_state == S_RUN) begin
      if (m_dir ? az : am) m_state = S_DONE;
      else exp_en++;
    end
  endtask

  task automatic set_mode(input int md, input int ld);
    @(negedge clk);
    mode = 2'(md);
    load = 8'(ld);
    wait_clk(3);
    if (m_state == S_IDLE) m_ld = ref_preset(md, ld);
  endtask

  task automatic glitch();
    @(negedge clk);
    start_btn = 1'b1;
    wait_clk(2);
    start_btn = 1'b0;
    wait_clk(SETTLE);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst.running", running, 0);
    check("rst.done", done, 0);
    check("rst.cnt_ld", cnt_if.cnt_ld, 0);
    check("rst.ld_val", cnt_if.ld_val, 0);
    check("rst.cnt_en", cnt_if.cnt_en, 0);
    check("rst.cnt_dir", cnt_if.cnt_dir, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_state = S_IDLE;
    m_dir = 1'b0;
    m_ld = ref_preset(mode, load);
    @(posedge clk);
    #1;
    check("rel.cnt_ld", cnt_if.cnt_ld, 1);
    check("rel.ld_val", cnt_if.ld_val, m_ld);
    @(negedge clk);
  endtask

  initial begin
    int op;
    cnt_if.at_zero = 1'b0;
    cnt_if.at_max = 1'b0;
    #2;
    check("init.running", running, 0);
    check("init.cnt_ld", cnt_if.cnt_ld, 0);
    check("init.ld_val", cnt_if.ld_val, 0);
    do_reset();
    set_mode(0, 8'h00);
    compare_all("idle0");
    press(1, 0);
    compare_all("run0");
    repeat (5) do_tick(0, 0);
    compare_all("five_ticks");
    press(0, 1);
    compare_all("clear0");

    set_mode(3, 8'h3A);
    check("ld_3900", cnt_if.ld_val, 16'h3900);
    press(1, 0);
    compare_all("run3");
    do_tick(1, 0);
    compare_all("term_done");
    press(1, 0);
    compare_all("done_start");
    press(0, 1);
    compare_all("done_clear");

    set_mode(0, 8'h00);
    press(1, 0);
    press(1, 0);
    repeat (3) do_tick(0, 0);
    compare_all("pause");
    press(1, 0);
    compare_all("resume");
    press(0, 1);
    compare_all("clear1");

    press(1, 0);
    press(1, 1);
    compare_all("both");
    glitch();
    compare_all("glitch");

    press(1, 0);
    do_tick(0, 0);
    do_reset();
    set_mode(2, 8'h00);
    compare_all("rst_track");

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 3)
        do_tick($urandom_range(0, 5) == 0,
                $urandom_range(0, 5) == 0);
      else if (op == 4) press(1, 0);
      else if (op == 5) press(0, 1);
      else if (op == 6) press(1, 1);
      else if (op == 7)
        set_mode($urandom_range(0, 3),
                 $urandom_range(0, 255));
      else if (op == 8) glitch();
      else do_reset();
      compare_all($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
